// File: rtl/dsm_capture_if.sv
// Bundle of capture/readback signals between the DSM stream, the test host and dsm_capture.
// The master drives stream samples and host commands; the slave is the capture buffer.
interface dsm_capture_if #(
  parameter int MOD_BITS = 4,
  parameter int SAMPLES  = 256,
  localparam int PTR_BITS = $clog2(SAMPLES)
);
  logic [MOD_BITS-1:0] dsm_bit;
  logic                dsm_valid;
  logic                start;
  logic                stop;
  logic                rd_req;
  logic                busy;
  logic                done;
  logic [PTR_BITS:0]   count;
  logic [MOD_BITS-1:0] rd_data;
  logic                rd_valid;
  logic                rd_last;
  logic                rd_err;
  logic                overflow;

  modport master (
    output dsm_bit, dsm_valid, start, stop, rd_req,
    input  busy, done, count, rd_data, rd_valid, rd_last, rd_err, overflow
  );

  modport slave (
    input  dsm_bit, dsm_valid, start, stop, rd_req,
    output busy, done, count, rd_data, rd_valid, rd_last, rd_err, overflow
  );
endinterface

// File: rtl/dsm_capture.sv
// Capture buffer for the DSM output stream: records up to SAMPLES words, then replays them on request.
// Define DSM_CAPTURE_OVF_EN to build the sticky dropped-sample (overflow) detector.
//
//   state   | meaning
//   IDLE    | no record armed; reads are rejected
//   CAPTURE | writing dsm_valid samples into the RAM
//   FULL    | record complete; host reads it back, wrapping for replay
module dsm_capture #(
  parameter int MOD_BITS = 4,
  parameter int SAMPLES  = 256,
  localparam int PTR_BITS = $clog2(SAMPLES)
) (
  input logic             i_internal_clk,
  input logic             i_internal_rst,
  dsm_capture_if.slave    bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;
  localparam int CNT_W = PTR_BITS + 1;
  localparam logic [PTR_BITS:0] LAST_CNT = CNT_W'(SAMPLES - 1);
  localparam logic [PTR_BITS:0] MAX_CNT  = CNT_W'(SAMPLES);

  logic [MOD_BITS-1:0] r_mem [SAMPLES];
  logic [1:0]          r_state;
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS:0]   r_count;
  logic                r_busy;
  logic                r_done;
  logic [MOD_BITS-1:0] r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_last;
  logic                r_rd_err;

  logic [1:0] w_state_nxt;
  logic       w_wr_en;
  logic       w_clr;
  logic       w_rd_go;
  logic       w_rd_last;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = CAPTURE;
          w_clr       = 1'b1;
        end
      end
      CAPTURE: begin
        if (bus.start) begin
          w_clr = 1'b1;
        end else begin
          w_wr_en = bus.dsm_valid;
          if (bus.stop || (bus.dsm_valid && r_count == LAST_CNT))
            w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (bus.start) begin
          w_state_nxt = CAPTURE;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_go   = bus.rd_req && (r_state == FULL) && (r_count != '0);
  assign w_rd_last = ({1'b0, r_rd_ptr} == (r_count - CNT_W'(1)));

  // RAM contents survive reset on purpose; only pointers and count are cleared.
  always_ff @(posedge i_internal_clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= bus.dsm_bit;
  end

  always_ff @(posedge i_internal_clk or posedge i_internal_rst) begin
    if (i_internal_rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == CAPTURE);
      r_done  <= (w_state_nxt == FULL);

      if (w_clr) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (w_wr_en && r_count != MAX_CNT) begin
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
        r_count  <= r_count + CNT_W'(1);
      end

      if (w_state_nxt == FULL && r_state != FULL)
        r_rd_ptr <= '0;
      else if (w_rd_go)
        r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + PTR_BITS'(1);

      r_rd_valid <= w_rd_go;
      r_rd_err   <= bus.rd_req && !w_rd_go;
      r_rd_last  <= w_rd_go && w_rd_last;
      r_rd_data  <= w_rd_go ? r_mem[r_rd_ptr] : '0;
    end
  end

`ifdef DSM_CAPTURE_OVF_EN
  logic r_overflow;
  logic r_rec_done;

  always_ff @(posedge i_internal_clk or posedge i_internal_rst) begin
    if (i_internal_rst) begin
      r_overflow <= 1'b0;
      r_rec_done <= 1'b0;
    end else begin
      if (w_state_nxt == FULL)
        r_rec_done <= 1'b1;
      if (bus.start)
        r_overflow <= 1'b0;
      else if (bus.dsm_valid && (r_state == FULL || (r_state == IDLE && r_rec_done)))
        r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.count    = r_count;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_last  = r_rd_last;
  assign bus.rd_err   = r_rd_err;
endmodule
